control_unit: RTL and testbench

Multicycle control FSM for the O9 processor; the counterpart of the datapath, which consumes every control strobe this block drives and returns the 6-bit opcode latched in its instruction register. The block sequences each instruction through fetch, decode, execute, memory and write-back states and asserts the matching datapath controls in each state. It also flags instruction completion and unsupported opcodes for the bench and the debug logic.

---
 rtl/control_unit.sv | 183 ++++++++++++++++++
 tb/tb_control_unit.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// control_unit: multicycle Moore control FSM for the O9 processor.
// Sequences fetch, decode, execute, memory and write-back, and drives the
// datapath strobes for the current state. While reset is low, every output
// is forced to zero so that no write strobe can fire.
module control_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opCode,
  output logic       PCWriteCond,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] PCSource,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    FETCH0    = 4'd0,
    FETCH1    = 4'd1,
    DECODE    = 4'd2,
    MEM_ADDR  = 4'd3,
    MEM_READ  = 4'd4,
    MEM_WB    = 4'd5,
    MEM_WRITE = 4'd6,
    R_EXEC    = 4'd7,
    R_WB      = 4'd8,
    BRANCH    = 4'd9,
    JUMP      = 4'd10,
    I_EXEC    = 4'd11,
    I_WB      = 4'd12
  } state_t;

  state_t state_q, state_d;

  // State register; a low reset on any rising edge returns to FETCH0.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= FETCH0;
    else        state_q <= state_d;
  end

  // Next-state and Moore outputs; reset low overrides everything with zeros.
  always_comb begin
    state_d     = FETCH0;
    PCWriteCond = 1'b0;
    PCWrite     = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    PCSource    = 2'b00;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    state       = state_q;

    case (state_q)
      FETCH0: begin
        MemRead = 1'b1;
        state_d = FETCH1;
      end
      FETCH1: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        ALUSrcB = 2'b01;
        PCWrite = 1'b1;
        state_d = DECODE;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (opCode)
          OP_LW, OP_SW: state_d = MEM_ADDR;
          OP_RTYPE:     state_d = R_EXEC;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
          OP_ADDI:      state_d = I_EXEC;
          default: begin
            state_d    = FETCH0;
            illegal_op = 1'b1;
            instr_done = 1'b1;
          end
        endcase
      end
      MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        if (opCode == OP_LW)      state_d = MEM_READ;
        else if (opCode == OP_SW) state_d = MEM_WRITE;
        else                      state_d = FETCH0;
      end
      MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        state_d = MEM_WB;
      end
      MEM_WB: begin
        MemtoReg   = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      MEM_WRITE: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = 1'b1;
      end
      R_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        state_d = R_WB;
      end
      R_WB: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        instr_done  = 1'b1;
      end
      JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        instr_done = 1'b1;
      end
      I_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = I_WB;
      end
      I_WB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      default: begin
        state_d = FETCH0;
      end
    endcase

    if (!reset) begin
      PCWriteCond = 1'b0;
      PCWrite     = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      MemtoReg    = 1'b0;
      IRWrite     = 1'b0;
      ALUSrcA     = 1'b0;
      RegWrite    = 1'b0;
      RegDst      = 1'b0;
      PCSource    = 2'b00;
      ALUSrcB     = 2'b00;
      ALUOp       = 2'b00;
      instr_done  = 1'b0;
      illegal_op  = 1'b0;
      state       = 4'd0;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: scoreboard bench for control_unit. The stimulus process
// drives reset/opCode each cycle and queues the expected output vector for
// that cycle; an independent monitor pops and compares on the falling edge.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] opCode = 6'b0;
  logic       PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg;
  logic       IRWrite, ALUSrcA, RegWrite, RegDst, instr_done, illegal_op;
  logic [1:0] PCSource, ALUSrcB, ALUOp;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;
  logic [21:0] expQ[$];

  control_unit dut (
    .clk(clk), .reset(reset), .opCode(opCode),
    .PCWriteCond(PCWriteCond), .PCWrite(PCWrite), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
    .RegDst(RegDst), .PCSource(PCSource), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .instr_done(instr_done), .illegal_op(illegal_op),
    .state(state)
  );

  always #5 clk = ~clk;

  // Hand-written table of the outputs each state must show.
  // Packing: {PCWriteCond,PCWrite,IorD,MemRead,MemWrite,MemtoReg,IRWrite,
  //           ALUSrcA,RegWrite,RegDst,PCSource,ALUSrcB,ALUOp,
  //           instr_done,illegal_op,state}
  function automatic logic [21:0] expVec(input int s, input logic ill);
    logic pcwc, pcw, iord, mr, mw, m2r, irw, asa, rw, rd, done, il;
    logic [1:0] pcs, asb, aop;
    logic [3:0] st;
    {pcwc, pcw, iord, mr, mw, m2r, irw, asa, rw, rd, done, il} = '0;
    pcs = 2'b00; asb = 2'b00; aop = 2'b00;
    st = (s < 0) ? 4'd0 : 4'(s);
    case (s)
      0:  begin mr = 1; end
      1:  begin mr = 1; irw = 1; asb = 2'b01; pcw = 1; end
      2:  begin asb = 2'b11; done = ill; il = ill; end
      3:  begin asa = 1; asb = 2'b10; end
      4:  begin mr = 1; iord = 1; end
      5:  begin m2r = 1; rw = 1; done = 1; end
      6:  begin mw = 1; iord = 1; done = 1; end
      7:  begin asa = 1; aop = 2'b10; end
      8:  begin rd = 1; rw = 1; done = 1; end
      9:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; done = 1; end
      10: begin pcw = 1; pcs = 2'b10; done = 1; end
      11: begin asa = 1; asb = 2'b10; end
      12: begin rw = 1; done = 1; end
      default: ;
    endcase
    return {pcwc, pcw, iord, mr, mw, m2r, irw, asa, rw, rd,
            pcs, asb, aop, done, il, st};
  endfunction

  // One cycle of stimulus: drive inputs after the edge, queue the expectation.
  task automatic applyStimulus(input logic rst, input logic [5:0] op,
                               input int s, input logic ill);
    @(posedge clk);
    #1;
    reset  = rst;
    opCode = op;
    expQ.push_back(rst ? expVec(s, ill) : 22'd0);
  endtask

  // Runs one instruction through its hand-computed state sequence. opCode is
  // randomised in cycles where it is don't-care.
  task automatic runInstr(input logic [5:0] op, input int n, input int seq[8],
                          input logic ill);
    for (int i = 0; i < n; i++) begin
      if (seq[i] == 2 || seq[i] == 3)
        applyStimulus(1'b1, op, seq[i], ill);
      else
        applyStimulus(1'b1, 6'($urandom), seq[i], ill);
    end
  endtask

  task automatic checkOutput(input logic [21:0] e);
    logic [21:0] act;
    act = {PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
           ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp,
           instr_done, illegal_op, state};
    checks++;
    if (act !== e) begin
      errors++;
      $display("[TB] FAIL outvec t=%0t got=%b expected=%b", $time, act, e);
    end
  endtask

  // Monitor: compares whatever the DUT shows against the queued expectation.
  always @(negedge clk) begin
    if (expQ.size() > 0) checkOutput(expQ.pop_front());
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int seq[8];
    // Reset held low for three edges: all outputs zero.
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 6'($urandom), 0, 1'b0);

    seq = '{0, 1, 2, 3, 4, 5, 0, 0};  runInstr(6'b100011, 6, seq, 1'b0); // lw
    seq = '{0, 1, 2, 3, 6, 0, 0, 0};  runInstr(6'b101011, 5, seq, 1'b0); // sw
    seq = '{0, 1, 2, 7, 8, 0, 0, 0};  runInstr(6'b000000, 5, seq, 1'b0); // R
    seq = '{0, 1, 2, 9, 0, 0, 0, 0};  runInstr(6'b000100, 4, seq, 1'b0); // beq
    seq = '{0, 1, 2, 10, 0, 0, 0, 0}; runInstr(6'b000010, 4, seq, 1'b0); // j
    seq = '{0, 1, 2, 11, 12, 0, 0, 0}; runInstr(6'b001000, 5, seq, 1'b0); // addi
    seq = '{0, 1, 2, 0, 0, 0, 0, 0};  runInstr(6'b111111, 3, seq, 1'b1); // illegal
    seq = '{0, 1, 2, 0, 0, 0, 0, 0};  runInstr(6'b010101, 3, seq, 1'b1); // illegal

    // Reset during R_WB: outputs drop in that cycle, then FETCH0.
    seq = '{0, 1, 2, 7, 0, 0, 0, 0};  runInstr(6'b000000, 4, seq, 1'b0);
    applyStimulus(1'b0, 6'b000000, 8, 1'b0);
    seq = '{0, 1, 2, 3, 6, 0, 0, 0};  runInstr(6'b101011, 5, seq, 1'b0);

    // Reset during MEM_WRITE aborts the store.
    seq = '{0, 1, 2, 3, 0, 0, 0, 0};  runInstr(6'b101011, 4, seq, 1'b0);
    applyStimulus(1'b0, 6'b101011, 6, 1'b0);
    applyStimulus(1'b0, 6'b101011, 6, 1'b0);
    seq = '{0, 1, 2, 9, 0, 0, 0, 0};  runInstr(6'b000100, 4, seq, 1'b0);

    repeat (3) @(posedge clk);
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain pending=%0d expected=0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
